// File: rtl/ext_tid_pkg.sv
// Shared constants and types for the external-unit transaction-ID scheduler.
// EXT_TID_WIDTH is also used by the TX/RX interfaces for their command TID field.
package ext_tid_pkg;

    localparam int EXT_TID_WIDTH = 4;
    localparam int NB_OUTSND_DEF = 8;

    typedef enum logic {
        REQ_TX = 1'b0,
        REQ_RX = 1'b1
    } t_tid_req;

endpackage

// File: rtl/ext_tid_prio_enc.sv
// Lowest-zero finder over the busy vector: returns the first free TID
// and whether any TID is free at all.
module ext_tid_prio_enc #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic [N-1:0] i_busy,
    output logic [W-1:0] o_idx,
    output logic         o_ne
);

    // Scan downwards so the lowest free index is written last and wins.
    always_comb begin
        o_idx = '0;
        o_ne  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_busy[i]) begin
                o_idx = W'(i);
                o_ne  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_tid_sched.sv
// TID pool shared by the external TX (AXI write) and RX (AXI read) paths:
// round-robin offer of the lowest free TID, freed again on B/R completion.
module ext_tid_sched #(
    parameter int EXT_TID_WIDTH = ext_tid_pkg::EXT_TID_WIDTH,
    parameter int NB_OUTSND     = ext_tid_pkg::NB_OUTSND_DEF,
    parameter int CNT_WIDTH     = $clog2(NB_OUTSND + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tx_pend_i,
    input  logic                     tx_take_i,
    output logic                     tx_valid_tid_o,
    output logic [EXT_TID_WIDTH-1:0] tx_tid_o,
    input  logic                     rx_pend_i,
    input  logic                     rx_take_i,
    output logic                     rx_valid_tid_o,
    output logic [EXT_TID_WIDTH-1:0] rx_tid_o,
    input  logic                     tx_release_i,
    input  logic [EXT_TID_WIDTH-1:0] tx_rel_tid_i,
    input  logic                     rx_release_i,
    input  logic [EXT_TID_WIDTH-1:0] rx_rel_tid_i,
    output logic [CNT_WIDTH-1:0]     outstanding_o,
    output logic                     idle_o,
    output logic                     err_o
);
    import ext_tid_pkg::*;

    logic [NB_OUTSND-1:0]     r_busy;
    t_tid_req                 r_rr;
    logic                     r_err;
    logic [CNT_WIDTH-1:0]     r_out;

    logic [EXT_TID_WIDTH-1:0] w_free_idx;
    logic                     w_pool_ne;
    logic                     w_offer_tx;
    logic                     w_offer_rx;
    logic                     w_tx_acc;
    logic                     w_rx_acc;
    logic                     w_alloc;
    logic                     w_tx_hit;
    logic                     w_rx_hit;
    logic                     w_dup;
    logic                     w_tx_rel;
    logic                     w_rx_rel;
    logic                     w_err_set;
    logic [NB_OUTSND-1:0]     w_busy_nxt;
    logic [1:0]               w_nrel;
    logic [CNT_WIDTH:0]       w_inc;
    logic [CNT_WIDTH:0]       w_dec;
    logic [CNT_WIDTH-1:0]     w_out_nxt;

    ext_tid_prio_enc #(
        .N (NB_OUTSND),
        .W (EXT_TID_WIDTH)
    ) u_prio_enc (
        .i_busy (r_busy),
        .o_idx  (w_free_idx),
        .o_ne   (w_pool_ne)
    );

    // Offers never look at the take inputs, so requesters may gate take on valid.
    assign w_offer_tx = w_pool_ne & tx_pend_i & (~rx_pend_i | (r_rr == REQ_TX));
    assign w_offer_rx = w_pool_ne & rx_pend_i & (~tx_pend_i | (r_rr == REQ_RX));

    assign tx_valid_tid_o = w_offer_tx;
    assign rx_valid_tid_o = w_offer_rx;
    assign tx_tid_o       = w_free_idx;
    assign rx_tid_o       = w_free_idx;

    assign w_tx_acc = tx_take_i & w_offer_tx;
    assign w_rx_acc = rx_take_i & w_offer_rx;
    assign w_alloc  = w_tx_acc | w_rx_acc;

    // Out-of-range TIDs never match an index, so they read as not busy.
    always_comb begin
        w_tx_hit = 1'b0;
        w_rx_hit = 1'b0;
        for (int i = 0; i < NB_OUTSND; i++) begin
            if (tx_rel_tid_i == EXT_TID_WIDTH'(i)) w_tx_hit = r_busy[i];
            if (rx_rel_tid_i == EXT_TID_WIDTH'(i)) w_rx_hit = r_busy[i];
        end
    end

    assign w_dup    = tx_release_i & rx_release_i & (tx_rel_tid_i == rx_rel_tid_i);
    assign w_tx_rel = tx_release_i & w_tx_hit;
    assign w_rx_rel = rx_release_i & w_rx_hit & ~w_dup;

    assign w_err_set = (tx_take_i & ~w_offer_tx)
                     | (rx_take_i & ~w_offer_rx)
                     | (tx_release_i & ~w_tx_hit)
                     | (rx_release_i & ~w_rx_hit)
                     | w_dup;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < NB_OUTSND; i++) begin
            if (w_alloc && w_free_idx == EXT_TID_WIDTH'(i)) w_busy_nxt[i] = 1'b1;
            if (w_tx_rel && tx_rel_tid_i == EXT_TID_WIDTH'(i)) w_busy_nxt[i] = 1'b0;
            if (w_rx_rel && rx_rel_tid_i == EXT_TID_WIDTH'(i)) w_busy_nxt[i] = 1'b0;
        end
    end

    assign w_nrel = {1'b0, w_tx_rel} + {1'b0, w_rx_rel};
    assign w_inc  = {1'b0, r_out} + (CNT_WIDTH + 1)'(w_alloc);
    assign w_dec  = w_inc - (CNT_WIDTH + 1)'(w_nrel);

    always_comb begin
        w_out_nxt = w_dec[CNT_WIDTH-1:0];
        if (w_inc < (CNT_WIDTH + 1)'(w_nrel)) begin
            w_out_nxt = '0;
        end else if (w_dec > (CNT_WIDTH + 1)'(NB_OUTSND)) begin
            w_out_nxt = CNT_WIDTH'(NB_OUTSND);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
            r_rr   <= REQ_TX;
            r_err  <= 1'b0;
            r_out  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_out  <= w_out_nxt;
            if (w_err_set) r_err <= 1'b1;
            if (w_tx_acc) r_rr <= REQ_RX;
            else if (w_rx_acc) r_rr <= REQ_TX;
        end
    end

    assign outstanding_o = r_out;
    assign idle_o        = (r_busy == '0);
    assign err_o         = r_err;

endmodule

// File: tb/tb_ext_tid_sched.sv
// Randomised bench for ext_tid_sched against a per-TID array model.
// Directed scenarios first, then legal and unrestricted random traffic.
module tb_ext_tid_sched;

    localparam int W  = ext_tid_pkg::EXT_TID_WIDTH;
    localparam int NB = ext_tid_pkg::NB_OUTSND_DEF;
    localparam int CW = $clog2(NB + 1);

    logic          clk;
    logic          rst;
    logic          tx_pend, tx_take, rx_pend, rx_take;
    logic          tx_valid, rx_valid;
    logic [W-1:0]  tx_tid, rx_tid;
    logic          tx_rel, rx_rel;
    logic [W-1:0]  tx_rel_tid, rx_rel_tid;
    logic [CW-1:0] outstanding;
    logic          idle, err;

    ext_tid_sched u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_pend_i      (tx_pend),
        .tx_take_i      (tx_take),
        .tx_valid_tid_o (tx_valid),
        .tx_tid_o       (tx_tid),
        .rx_pend_i      (rx_pend),
        .rx_take_i      (rx_take),
        .rx_valid_tid_o (rx_valid),
        .rx_tid_o       (rx_tid),
        .tx_release_i   (tx_rel),
        .tx_rel_tid_i   (tx_rel_tid),
        .rx_release_i   (rx_rel),
        .rx_rel_tid_i   (rx_rel_tid),
        .outstanding_o  (outstanding),
        .idle_o         (idle),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // model: one flag per TID, which side has priority, sticky error
    bit m_busy[NB];
    bit m_rr_rx;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_free();
        for (int i = 0; i < NB; i++)
            if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NB; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NB; i++) m_busy[i] = 1'b0;
        m_rr_rx = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic clr_in();
        tx_pend = 0; tx_take = 0; rx_pend = 0; rx_take = 0;
        tx_rel = 0; rx_rel = 0; tx_rel_tid = '0; rx_rel_tid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        m_reset();
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_out", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_rxv", rx_valid, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at negedge, check outputs, advance model for the edge.
    // With auto=1 the take bits mean "take if offered".
    task automatic step(input bit tp, input bit tk, input bit rp, input bit rk,
                        input bit trl, input int trt, input bit rrl, input int rrt,
                        input bit auto);
        int  f;
        bit  vtx, vrx, tke, rke, th, rh;
        @(negedge clk);
        f   = m_free();
        vtx = (f >= 0) && tp && (!rp || !m_rr_rx);
        vrx = (f >= 0) && rp && (!tp || m_rr_rx);
        tke = auto ? (tk && vtx) : tk;
        rke = auto ? (rk && vrx) : rk;
        tx_pend = tp; tx_take = tke; rx_pend = rp; rx_take = rke;
        tx_rel = trl; tx_rel_tid = W'(trt);
        rx_rel = rrl; rx_rel_tid = W'(rrt);
        #1;
        chk("tx_valid", tx_valid, vtx);
        chk("rx_valid", rx_valid, vrx);
        if (f >= 0) begin
            chk("tx_tid", tx_tid, f);
            chk("rx_tid", rx_tid, f);
        end
        chk("idle", idle, m_cnt() == 0);
        chk("outstanding", outstanding, m_cnt());
        chk("err", err, m_err);
        th = 0;
        rh = 0;
        if (trl && trt < NB) th = m_busy[trt];
        if (rrl && rrt < NB) rh = m_busy[rrt];
        if ((tke && !vtx) || (rke && !vrx)) m_err = 1;
        if ((trl && !th) || (rrl && !rh)) m_err = 1;
        if (trl && rrl && trt == rrt) m_err = 1;
        if (th) m_busy[trt] = 0;
        if (rh) m_busy[rrt] = 0;
        if ((tke && vtx) || (rke && vrx)) begin
            m_busy[f] = 1;
            m_rr_rx   = tke && vtx;
        end
    endtask

    initial begin
        int q[$];
        int a, b;
        bit ra, rb;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clr_in();
        m_reset();
        #12;
        rst = 1'b0;

        // 1: single TX allocation
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_tid1", tx_tid, 1);
        chk("t1_out1", outstanding, 1);

        // 2: alternating grants
        do_reset();
        repeat (4) step(1, 1, 1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_out4", outstanding, 4);

        // 3: pool exhaustion and refill
        do_reset();
        repeat (8) step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0, 1, 5, 0);
        chk("t3_full_txv", tx_valid, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("t3_tid5", tx_tid, 5);

        // 4: allocate and two releases in the same cycle
        do_reset();
        repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_out1", outstanding, 1);
        chk("t4_noerr", err, 0);

        // 5: protocol errors are sticky
        do_reset();
        step(0, 0, 0, 0, 1, 7, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 12, 0);
        chk("t5_err", err, 1);
        do_reset();

        // 6: asynchronous reset mid-cycle
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        chk("t6_pre_out", outstanding, 3);
        clr_in();
        rst = 1'b1;
        #1;
        chk("t6_idle", idle, 1);
        chk("t6_out", outstanding, 0);
        chk("t6_err", err, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_tid0", tx_tid, 0);

        // legal random traffic
        do_reset();
        repeat (600) begin
            q.delete();
            for (int i = 0; i < NB; i++) if (m_busy[i]) q.push_back(i);
            ra = 0; rb = 0; a = 0; b = 0;
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                ra = 1;
                a  = q[$urandom_range(0, q.size() - 1)];
            end
            if (q.size() > 1 && $urandom_range(0, 2) == 0) begin
                b = q[$urandom_range(0, q.size() - 1)];
                rb = (b != a) || !ra;
            end
            step(1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 ra, a, rb, b, 1);
        end

        // unrestricted random traffic, including protocol violations
        do_reset();
        repeat (300) begin
            step(1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 5) == 0), $urandom_range(0, 15),
                 1'($urandom_range(0, 5) == 0), $urandom_range(0, 15), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
